prod_mean_sat: RTL and testbench
================================

// Module: prod_mean_sat
// PURPOSE
//   Consumes the signed 15-bit product stream (E) of the subtract/multiply stage and accumulates
//   windows of 2**LOG2_N valid samples. Emits the rounded mean saturated to OUT_W bits with a
//   one-cycle valid pulse and a saturation flag. Sits directly downstream of the arithmetic stage.
// PARAMETERS
//   IN_W    15  width of signed input sample din
//   OUT_W   8   width of signed result dout
//   LOG2_N  3   log2 of window length N (N = 8 by default). Legal range 1..8.
//   ACC_W   IN_W+LOG2_N  localparam: accumulator width. Cannot overflow.
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   n_rst       in   1      synchronous, active-low reset
//   en          in   1      din valid this cycle
//   clr         in   1      synchronous window abort
//   din         in   IN_W   signed sample
//   dout        out  OUT_W  signed saturated mean; holds until next result
//   dout_valid  out  1      one-cycle pulse: dout updated this cycle
//   ovf         out  1      dout was clamped; updated together with dout_valid
//   busy        out  1      high while a partial window is held (state ACC)
// BEHAVIOUR
//   Reset (n_rst=0 at posedge)
//     - state=IDLE, acc=0, cnt=0
//     - dout=0, dout_valid=0, ovf=0, busy=0
//     - Reset mid-window discards the partial sum; no output is produced.
//   Priority at each posedge: n_rst > clr > en.
//   FSM
//     - IDLE, en=1: acc<=sext(din), cnt<=1, go to ACC.
//     - ACC, en=1, cnt<N-1: acc<=acc+din, cnt<=cnt+1.
//     - ACC, en=1, cnt==N-1: sum=acc+din (final sample); acc<=0, cnt<=0, go to IDLE.
//         Register result; dout_valid=1 in the following cycle.
//     - en=0: acc, cnt and state hold. Gaps between samples are allowed.
//   clr=1: acc<=0, cnt<=0, state<=IDLE, dout_valid<=0. dout and ovf hold.
//   Mean arithmetic
//     - m = (sum + 2**(LOG2_N-1)) >>> LOG2_N, computed in ACC_W+1 bits.
//       This is arithmetic shift, i.e. round half toward +inf.
//     - If m > 2**(OUT_W-1)-1: dout = max positive, ovf=1.
//     - If m < -2**(OUT_W-1): dout = min negative, ovf=1.
//     - Otherwise: dout = m[OUT_W-1:0], ovf=0.
//   Latency
//     - dout_valid is asserted exactly 1 cycle after the posedge that accepts the Nth sample.
//     - dout_valid is 0 in all other cycles.
//   Back-to-back windows
//     - With en held high, windows are contiguous: sample N+1 is accepted in IDLE on the
//       next cycle, with no dead cycle.
//     - The valid pulses are exactly N cycles apart.
//   busy = (state==ACC).
// TESTING (LOG2_N=3, IN_W=15, OUT_W=8)
//   1 Reset: n_rst=0 for 2 cycles with en=1, din=100
//       -> dout=0, dout_valid=0, ovf=0, busy=0 throughout.
//   2 Rounding, positive: din=1..8 on 8 consecutive en cycles
//       -> 1 cycle after the 8th: dout_valid=1, dout=5, ovf=0.
//   3 Rounding, negative: din=-1..-8
//       -> dout=-4, ovf=0.
//   4 Saturation: 8 samples of 16383
//       -> dout=127, ovf=1.
//     Then 8 samples of -16384
//       -> dout=-128, ovf=1.
//   5 Gaps and abort
//       - 4 samples with en toggling every other cycle, then clr=1
//         -> busy=0, no dout_valid.
//       - Then 8 samples of 5 with en toggling every other cycle
//         -> a single pulse with dout=5.
//       - clr and en high in the same cycle -> the sample is dropped.
//   6 Continuous and reset-abort
//       - 16 samples with en=1 continuously: 8 x 2, then 8 x 4
//         -> two pulses 8 cycles apart, dout=2 then dout=4.
//       - n_rst=0 after 5 samples of 9, then 8 samples of -7
//         -> dout=-7, ovf=0.

Source files
------------

// File: rtl/prod_mean_sat.sv
`default_nettype none
// ============================================================================
// Module      : prod_mean_sat
// Description : Windowed rounded-mean unit for the signed product stream of
//               the subtract/multiply stage. It accumulates 2**LOG2_N valid
//               samples, divides by the window length with
//               round-half-toward-+inf, saturates to OUT_W bits, and emits
//               the result with a one-cycle valid pulse and a clamp flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1      system clock, rising edge
//   n_rst       in   1      synchronous active-low reset
//   en          in   1      din valid this cycle
//   clr         in   1      synchronous window abort (dout/ovf hold)
//   din         in   IN_W   signed sample
//   dout        out  OUT_W  signed saturated mean, held until next result
//   dout_valid  out  1      one-cycle pulse: dout updated this cycle
//   ovf         out  1      dout was clamped (updated with dout_valid)
//   busy        out  1      a partial window is held
// ============================================================================
module prod_mean_sat #(
    parameter int IN_W   = 15,
    parameter int OUT_W  = 8,
    parameter int LOG2_N = 3
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    ovf,
    output logic                    busy
);

    // Sum of N samples of IN_W bits needs at most IN_W+LOG2_N bits.
    localparam int ACC_W = IN_W + LOG2_N;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_acc  = 1'b1;

    // Sample count at which the incoming sample completes the window.
    localparam logic [LOG2_N-1:0] c_cnt_last = '1;
    localparam logic [LOG2_N-1:0] c_cnt_one  = LOG2_N'(1);

    // Rounding offset and saturation bounds in the mean's working width.
    localparam logic signed [ACC_W:0] c_half    = (ACC_W+1)'(1) << (LOG2_N - 1);
    localparam logic signed [ACC_W:0] c_max     = (ACC_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] c_min     = (ACC_W+1)'(-(2**(OUT_W-1)));
    localparam logic signed [OUT_W-1:0] c_out_max = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_out_min = {1'b1, {(OUT_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [0:0]              r_state_q,      w_state_d;
    logic signed [ACC_W-1:0] r_acc_q,        w_acc_d;
    logic [LOG2_N-1:0]       r_cnt_q,        w_cnt_d;
    logic signed [OUT_W-1:0] r_dout_q,       w_dout_d;
    logic                    r_dout_valid_q, w_dout_valid_d;
    logic                    r_ovf_q,        w_ovf_d;

    // ------------------------------------------------------------------
    // Arithmetic on the sample that would close the window
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_din_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_mean;
    logic signed [OUT_W-1:0] w_sat_dout;
    logic                    w_sat_ovf;

    always_comb begin
        w_din_ext = {{LOG2_N{din[IN_W-1]}}, din};
        w_sum     = r_acc_q + w_din_ext;
        // One extra bit so adding the rounding offset cannot wrap.
        w_rnd     = {w_sum[ACC_W-1], w_sum} + c_half;
        // Arithmetic shift floors, so +half then floor rounds half up.
        w_mean    = w_rnd >>> LOG2_N;

        w_sat_dout = w_mean[OUT_W-1:0];
        w_sat_ovf  = 1'b0;
        if (w_mean > c_max) begin
            w_sat_dout = c_out_max;
            w_sat_ovf  = 1'b1;
        end else if (w_mean < c_min) begin
            w_sat_dout = c_out_min;
            w_sat_ovf  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state_q      <= c_st_idle;
            r_acc_q        <= '0;
            r_cnt_q        <= '0;
            r_dout_q       <= '0;
            r_dout_valid_q <= 1'b0;
            r_ovf_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_acc_q        <= w_acc_d;
            r_cnt_q        <= w_cnt_d;
            r_dout_q       <= w_dout_d;
            r_dout_valid_q <= w_dout_valid_d;
            r_ovf_q        <= w_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_acc_d        = r_acc_q;
        w_cnt_d        = r_cnt_q;
        w_dout_d       = r_dout_q;
        w_ovf_d        = r_ovf_q;
        w_dout_valid_d = 1'b0;

        if (clr) begin
            // Abort drops the partial window; a sample offered now is lost.
            w_state_d = c_st_idle;
            w_acc_d   = '0;
            w_cnt_d   = '0;
        end else if (en) begin
            case (r_state_q)
                c_st_idle: begin
                    w_acc_d   = w_din_ext;
                    w_cnt_d   = c_cnt_one;
                    w_state_d = c_st_acc;
                end
                c_st_acc: begin
                    if (r_cnt_q == c_cnt_last) begin
                        // Final sample: publish the mean and start afresh so
                        // the next sample opens a new window without a gap.
                        w_acc_d        = '0;
                        w_cnt_d        = '0;
                        w_state_d      = c_st_idle;
                        w_dout_d       = w_sat_dout;
                        w_ovf_d        = w_sat_ovf;
                        w_dout_valid_d = 1'b1;
                    end else begin
                        w_acc_d = w_sum;
                        w_cnt_d = r_cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    w_state_d = c_st_idle;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        dout       = r_dout_q;
        dout_valid = r_dout_valid_q;
        ovf        = r_ovf_q;
        busy       = (r_state_q == c_st_acc);
    end

endmodule
`default_nettype wire

// File: tb/tb_prod_mean_sat.sv
`default_nettype none
// ============================================================================
// Module      : tb_prod_mean_sat
// Description : Directed self-checking bench for prod_mean_sat
//               (IN_W=15, OUT_W=8, LOG2_N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prod_mean_sat;

    logic               clk;
    logic               n_rst;
    logic               en;
    logic               clr;
    logic signed [14:0] din;
    logic signed [7:0]  dout;
    logic               dout_valid;
    logic               ovf;
    logic               busy;

    int checks = 0;
    int errors = 0;

    prod_mean_sat #(
        .IN_W   (15),
        .OUT_W  (8),
        .LOG2_N (3)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .clr        (clr),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input int v);
        en  = 1'b1;
        din = 15'(v);
        tick();
    endtask

    task automatic check_out(input string tag, input int exp_dout, input int exp_ovf);
        check({tag, "_valid"}, {31'b0, dout_valid}, 1);
        check({tag, "_dout"}, $signed(dout), exp_dout);
        check({tag, "_ovf"}, {31'b0, ovf}, exp_ovf);
        check({tag, "_busy"}, {31'b0, busy}, 0);
    endtask

    // Eight samples base, base+step, ...; en stays high unless drop is set.
    task automatic window(input string tag, input int base, input int step,
                          input int exp_dout, input int exp_ovf, input bit drop);
        for (int i = 0; i < 8; i++) begin
            feed(base + i * step);
            if (i < 7) begin
                check({tag, "_novalid"}, {31'b0, dout_valid}, 0);
                check({tag, "_busy"}, {31'b0, busy}, 1);
            end
        end
        check_out(tag, exp_dout, exp_ovf);
        if (drop) begin
            en = 1'b0;
            tick();
            check({tag, "_pulse_end"}, {31'b0, dout_valid}, 0);
            check({tag, "_hold"}, $signed(dout), exp_dout);
        end
    endtask

    initial begin
        int pulses;
        n_rst = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        din   = 15'sd100;

        // 1: reset with en asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_dout", $signed(dout), 0);
            check("rst_valid", {31'b0, dout_valid}, 0);
            check("rst_ovf", {31'b0, ovf}, 0);
            check("rst_busy", {31'b0, busy}, 0);
        end
        en    = 1'b0;
        n_rst = 1'b1;
        tick();
        check("post_rst_busy", {31'b0, busy}, 0);

        // 2: 1..8 -> (36+4)>>3 = 5
        window("pos", 1, 1, 5, 0, 1'b1);
        // 3: -1..-8 -> (-36+4)>>>3 = -4
        window("neg", -1, -1, -4, 0, 1'b1);
        // 4: saturation both ways
        window("satp", 16383, 0, 127, 1, 1'b1);
        window("satn", -16384, 0, -128, 1, 1'b1);

        // 5a: 4 gapped samples then abort
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            feed(50);
            pulses += int'(dout_valid);
            en = 1'b0;
            tick();
            pulses += int'(dout_valid);
        end
        check("gap_busy_before_clr", {31'b0, busy}, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulses += int'(dout_valid);
        check("clr_busy", {31'b0, busy}, 0);
        check("clr_no_pulse", pulses, 0);
        check("clr_dout_hold", $signed(dout), -128);
        check("clr_ovf_hold", {31'b0, ovf}, 1);

        // 5b: 8 gapped samples of 5 -> single pulse, dout=5
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            feed(5);
            pulses += int'(dout_valid);
            if (i == 7) check_out("gap5", 5, 0);
            en = 1'b0;
            tick();
            pulses += int'(dout_valid);
        end
        check("gap5_pulses", pulses, 1);

        // 5c: clr with en drops the sample; next 8 samples of 3 give 3
        clr = 1'b1;
        feed(100);
        clr = 1'b0;
        check("clr_en_busy", {31'b0, busy}, 0);
        check("clr_en_valid", {31'b0, dout_valid}, 0);
        window("after_clr_en", 3, 0, 3, 0, 1'b1);

        // 6a: continuous windows, pulses 8 cycles apart
        window("cont2", 2, 0, 2, 0, 1'b0);
        window("cont4", 4, 0, 4, 0, 1'b1);

        // 6b: reset mid-window, then a clean window of -7
        for (int i = 0; i < 5; i++) feed(9);
        en    = 1'b0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("rst_mid_busy", {31'b0, busy}, 0);
        check("rst_mid_valid", {31'b0, dout_valid}, 0);
        check("rst_mid_dout", $signed(dout), 0);
        window("after_rst", -7, 0, -7, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
